// File: rtl/dm_multihart.sv
// RISC-V debug module (0.13.2 register map) for up to 32 harts with a
// handshaked abstract register engine and a system-bus master engine.
module dm_multihart #(
    parameter int NHARTS       = 4,
    parameter int DATA_COUNT   = 2,
    parameter int PROGBUF_SIZE = 4,
    parameter int SB_TIMEOUT   = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dmi_wr,
    input  logic              i_dmi_rd,
    input  logic [6:0]        i_dmi_addr,
    input  logic [31:0]       i_dmi_wdata,
    output logic [31:0]       o_dmi_rdata,
    output logic [NHARTS-1:0] o_haltreq,
    output logic [NHARTS-1:0] o_resumereq,
    input  logic [NHARTS-1:0] i_halted,
    input  logic [NHARTS-1:0] i_resumeack,
    output logic              o_reg_req,
    output logic              o_reg_write,
    output logic [4:0]        o_reg_hart,
    output logic [15:0]       o_reg_addr,
    output logic [31:0]       o_reg_wdata,
    input  logic              i_reg_ack,
    input  logic              i_reg_err,
    input  logic [31:0]       i_reg_rdata,
    output logic              o_sb_req,
    output logic              o_sb_we,
    output logic [31:0]       o_sb_addr,
    output logic [31:0]       o_sb_wdata,
    input  logic              i_sb_ready,
    input  logic              i_sb_err,
    input  logic [31:0]       i_sb_rdata
);
    localparam logic [6:0] A_DATA0      = 7'h04;
    localparam logic [6:0] A_DATA_END   = 7'(4 + DATA_COUNT);
    localparam logic [6:0] A_DMCONTROL  = 7'h10;
    localparam logic [6:0] A_DMSTATUS   = 7'h11;
    localparam logic [6:0] A_ABSTRACTCS = 7'h16;
    localparam logic [6:0] A_COMMAND    = 7'h17;
    localparam logic [6:0] A_SBCS       = 7'h38;
    localparam logic [6:0] A_SBADDR0    = 7'h39;
    localparam logic [6:0] A_SBDATA0    = 7'h3C;
    localparam logic [5:0] NH           = 6'(NHARTS);
    localparam int         PB_N         = (PROGBUF_SIZE == 0) ? 1 : PROGBUF_SIZE;
    localparam int         CW           = $clog2(SB_TIMEOUT + 1);

    typedef enum logic [1:0] {AB_IDLE, AB_REQ, AB_DONE} ab_state_t;

    logic        r_dmactive, r_haltreq;
    logic [4:0]  r_hartsel;
    logic [31:0] r_dmi_rdata;
    ab_state_t   r_ab_state, w_ab_next;
    logic [2:0]  r_cmderr;
    logic        r_reg_write;
    logic [4:0]  r_reg_hart;
    logic [15:0] r_reg_addr;
    logic [31:0] r_reg_wdata;
    logic        r_sbbusyerror, r_sbreadonaddr, r_sbautoinc, r_sbreadondata;
    logic [2:0]  r_sbaccess, r_sberror;
    logic [31:0] r_sbaddr, r_sbdata, r_sb_addr_o, r_sb_wdata_o;
    logic        r_sb_req, r_sb_we;
    logic [CW-1:0] r_sb_cnt;

    logic [31:0] w_data [DATA_COUNT];
    logic [31:0] w_prog [PB_N];
    logic [NHARTS-1:0] w_flag;
    logic [31:0] w_halted_ext, w_flag_ext, w_rdata, w_status;
    logic        w_wr_dmctl, w_clear, w_wr_cmd, w_wr_acs, w_wr_data_any, w_data_busy;
    logic        w_wr_sbcs, w_wr_sbaddr, w_wr_sbdata, w_rd_sbdata;
    logic        w_sel_exists, w_sel_halted, w_sel_ack, w_busy, w_cmd_bad, w_cmd_ok;
    logic        w_cmd_go, w_cmd_nop, w_ab_ack;
    logic        w_sb_try, w_sb_ok, w_sb_go, w_sb_done, w_sb_tmo;
    logic        w_unused;

    assign w_unused      = &{1'b0, i_dmi_wdata[23]};
    assign w_wr_dmctl    = i_dmi_wr && (i_dmi_addr == A_DMCONTROL);
    // Writing dmactive=0 is a synchronous clear of the whole module.
    assign w_clear       = w_wr_dmctl && !i_dmi_wdata[0];
    assign w_wr_cmd      = i_dmi_wr && (i_dmi_addr == A_COMMAND);
    assign w_wr_acs      = i_dmi_wr && (i_dmi_addr == A_ABSTRACTCS);
    assign w_wr_data_any = i_dmi_wr && (i_dmi_addr >= A_DATA0) && (i_dmi_addr < A_DATA_END);
    assign w_wr_sbcs     = i_dmi_wr && (i_dmi_addr == A_SBCS);
    assign w_wr_sbaddr   = i_dmi_wr && (i_dmi_addr == A_SBADDR0);
    assign w_wr_sbdata   = i_dmi_wr && (i_dmi_addr == A_SBDATA0);
    assign w_rd_sbdata   = i_dmi_rd && (i_dmi_addr == A_SBDATA0);

    assign w_halted_ext  = 32'(i_halted);
    assign w_flag_ext    = 32'(w_flag);
    assign w_sel_exists  = {1'b0, r_hartsel} < NH;
    assign w_sel_halted  = w_sel_exists && w_halted_ext[r_hartsel];
    assign w_sel_ack     = w_sel_exists && w_flag_ext[r_hartsel];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || w_clear) begin
            r_dmactive <= 1'b0;
            r_haltreq  <= 1'b0;
            r_hartsel  <= '0;
        end else if (w_wr_dmctl) begin
            r_dmactive <= 1'b1;
            r_haltreq  <= i_dmi_wdata[31];
            r_hartsel  <= i_dmi_wdata[20:16];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NHARTS; gi++) begin : g_hart
            logic r_req, r_flag;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_req  <= 1'b0;
                    r_flag <= 1'b0;
                end else if (w_clear) begin
                    r_req  <= 1'b0;
                    r_flag <= 1'b0;
                end else begin
                    if (i_resumeack[gi]) begin
                        r_req  <= 1'b0;
                        r_flag <= 1'b1;
                    end
                    if (w_wr_dmctl && i_dmi_wdata[30] && !i_dmi_wdata[31] &&
                        i_dmi_wdata[20:16] == 5'(gi)) begin
                        r_req  <= 1'b1;
                        r_flag <= 1'b0;
                    end
                end
            end
            assign o_haltreq[gi]   = r_haltreq && (r_hartsel == 5'(gi));
            assign o_resumereq[gi] = r_req;
            assign w_flag[gi]      = r_flag;
        end
    endgenerate

    assign w_busy    = (r_ab_state != AB_IDLE);
    assign w_cmd_bad = (i_dmi_wdata[31:24] != 8'd0) || (i_dmi_wdata[22:20] != 3'd2) || i_dmi_wdata[18];
    assign w_cmd_ok  = w_wr_cmd && !w_busy && (r_cmderr == 3'd0) && !w_cmd_bad && w_sel_halted;
    assign w_cmd_go  = w_cmd_ok && i_dmi_wdata[17];
    assign w_cmd_nop = w_cmd_ok && !i_dmi_wdata[17];
    assign w_ab_ack  = (r_ab_state == AB_REQ) && i_reg_ack;
    assign w_data_busy = w_wr_data_any && w_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ab_state <= AB_IDLE;
        else          r_ab_state <= w_ab_next;
    end

    always_comb begin
        w_ab_next = r_ab_state;
        case (r_ab_state)
            AB_IDLE: if (w_cmd_go) w_ab_next = AB_REQ;
                     else if (w_cmd_nop) w_ab_next = AB_DONE;
            AB_REQ:  if (i_reg_ack) w_ab_next = AB_DONE;
            AB_DONE: w_ab_next = AB_IDLE;
            default: w_ab_next = AB_IDLE;
        endcase
        if (w_clear) w_ab_next = AB_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || w_clear) begin
            r_cmderr    <= 3'd0;
            r_reg_write <= 1'b0;
            r_reg_hart  <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
        end else begin
            if (w_wr_acs) r_cmderr <= r_cmderr & ~i_dmi_wdata[10:8];
            if (w_wr_cmd) begin
                if (w_busy) r_cmderr <= 3'd1;
                else if (r_cmderr == 3'd0) begin
                    if (w_cmd_bad)          r_cmderr <= 3'd2;
                    else if (!w_sel_halted) r_cmderr <= 3'd4;
                end
            end
            if (w_data_busy)           r_cmderr <= 3'd1;
            if (w_ab_ack && i_reg_err) r_cmderr <= 3'd3;
            if (w_cmd_go) begin
                r_reg_write <= i_dmi_wdata[16];
                r_reg_hart  <= r_hartsel;
                r_reg_addr  <= i_dmi_wdata[15:0];
                r_reg_wdata <= w_data[0];
            end
        end
    end

    generate
        for (gi = 0; gi < DATA_COUNT; gi++) begin : g_data
            localparam logic [6:0] ADDR = 7'(4 + gi);
            logic [31:0] r_word;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n || w_clear)
                    r_word <= '0;
                else if (gi == 0 && w_ab_ack && !i_reg_err && !r_reg_write)
                    r_word <= i_reg_rdata;
                else if (i_dmi_wr && i_dmi_addr == ADDR && !w_busy)
                    r_word <= i_dmi_wdata;
            end
            assign w_data[gi] = r_word;
        end
        if (PROGBUF_SIZE == 0) begin : g_noprog
            assign w_prog[0] = '0;
        end
        for (gi = 0; gi < PROGBUF_SIZE; gi++) begin : g_prog
            localparam logic [6:0] ADDR = 7'(32 + gi);
            logic [31:0] r_word;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n || w_clear)                      r_word <= '0;
                else if (i_dmi_wr && i_dmi_addr == ADDR)      r_word <= i_dmi_wdata;
            end
            assign w_prog[gi] = r_word;
        end
    endgenerate

    // System bus: a start is only accepted with no pending error and an idle engine.
    assign w_sb_try  = (w_wr_sbaddr && r_sbreadonaddr) || w_wr_sbdata || (w_rd_sbdata && r_sbreadondata);
    assign w_sb_ok   = w_sb_try && !r_sb_req && (r_sberror == 3'd0) && !r_sbbusyerror;
    assign w_sb_go   = w_sb_ok && (r_sbaccess == 3'd2);
    assign w_sb_done = r_sb_req && i_sb_ready;
    assign w_sb_tmo  = r_sb_req && !i_sb_ready && (r_sb_cnt == CW'(SB_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || w_clear) begin
            r_sbbusyerror  <= 1'b0;
            r_sbreadonaddr <= 1'b0;
            r_sbaccess     <= 3'd2;
            r_sbautoinc    <= 1'b0;
            r_sbreadondata <= 1'b0;
            r_sberror      <= 3'd0;
            r_sbaddr       <= '0;
            r_sbdata       <= '0;
            r_sb_req       <= 1'b0;
            r_sb_we        <= 1'b0;
            r_sb_addr_o    <= '0;
            r_sb_wdata_o   <= '0;
            r_sb_cnt       <= '0;
        end else begin
            if (w_wr_sbcs) begin
                r_sbbusyerror  <= r_sbbusyerror & ~i_dmi_wdata[22];
                r_sbreadonaddr <= i_dmi_wdata[20];
                r_sbaccess     <= i_dmi_wdata[19:17];
                r_sbautoinc    <= i_dmi_wdata[16];
                r_sbreadondata <= i_dmi_wdata[15];
                r_sberror      <= r_sberror & ~i_dmi_wdata[14:12];
            end
            if (w_sb_try && r_sb_req)               r_sbbusyerror <= 1'b1;
            if (w_sb_ok && r_sbaccess != 3'd2)      r_sberror <= 3'd4;
            if (w_wr_sbaddr)                        r_sbaddr <= i_dmi_wdata;
            if (w_wr_sbdata)                        r_sbdata <= i_dmi_wdata;
            if (w_sb_go) begin
                r_sb_req     <= 1'b1;
                r_sb_we      <= w_wr_sbdata;
                r_sb_addr_o  <= w_wr_sbaddr ? i_dmi_wdata : r_sbaddr;
                r_sb_wdata_o <= i_dmi_wdata;
                r_sb_cnt     <= '0;
            end
            if (w_sb_done) begin
                r_sb_req <= 1'b0;
                if (i_sb_err) r_sberror <= 3'd7;
                else begin
                    if (!r_sb_we)   r_sbdata <= i_sb_rdata;
                    if (r_sbautoinc) r_sbaddr <= r_sbaddr + 32'd4;
                end
            end else if (w_sb_tmo) begin
                r_sb_req  <= 1'b0;
                r_sberror <= 3'd1;
            end else if (r_sb_req) begin
                r_sb_cnt <= r_sb_cnt + 1'b1;
            end
        end
    end

    assign w_status = {9'd0, 1'b0, 2'b00, 2'b00, w_sel_ack, w_sel_ack, !w_sel_exists, !w_sel_exists,
                       2'b00, w_sel_exists && !w_sel_halted, w_sel_exists && !w_sel_halted,
                       w_sel_halted, w_sel_halted, 1'b1, 3'b000, 4'd2};

    always_comb begin
        w_rdata = '0;
        case (i_dmi_addr)
            A_DMCONTROL:  w_rdata = {r_haltreq, 10'd0, r_hartsel, 15'd0, r_dmactive};
            A_DMSTATUS:   w_rdata = w_status;
            A_ABSTRACTCS: w_rdata = {3'd0, 5'(PROGBUF_SIZE), 11'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'(DATA_COUNT)};
            A_SBCS:       w_rdata = {3'd1, 6'd0, r_sbbusyerror, r_sb_req, r_sbreadonaddr, r_sbaccess,
                                     r_sbautoinc, r_sbreadondata, r_sberror, 7'd32, 5'b00100};
            A_SBADDR0:    w_rdata = r_sbaddr;
            A_SBDATA0:    w_rdata = r_sbdata;
            default: begin
                for (int i = 0; i < DATA_COUNT; i++)
                    if (i_dmi_addr == 7'(4 + i)) w_rdata = w_data[i];
                for (int i = 0; i < PROGBUF_SIZE; i++)
                    if (i_dmi_addr == 7'(32 + i)) w_rdata = w_prog[i];
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || w_clear) r_dmi_rdata <= '0;
        else if (i_dmi_rd)       r_dmi_rdata <= w_rdata;
    end

    assign o_dmi_rdata = r_dmi_rdata;
    assign o_reg_req   = (r_ab_state == AB_REQ) && !w_clear;
    assign o_reg_write = r_reg_write;
    assign o_reg_hart  = r_reg_hart;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_sb_req    = r_sb_req && !w_clear;
    assign o_sb_we     = r_sb_we;
    assign o_sb_addr   = r_sb_addr_o;
    assign o_sb_wdata  = r_sb_wdata_o;
endmodule

// File: tb/tb_dm_multihart.sv
// Directed self-checking bench for dm_multihart: DMI register access,
// abstract command handshake, system-bus engine and dmactive clear.
module tb_dm_multihart;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_dmi_wr = 1'b0, i_dmi_rd = 1'b0;
    logic [6:0]  i_dmi_addr = '0;
    logic [31:0] i_dmi_wdata = '0;
    logic [31:0] o_dmi_rdata;
    logic [3:0]  o_haltreq, o_resumereq;
    logic [3:0]  i_halted = '0, i_resumeack = '0;
    logic        o_reg_req, o_reg_write;
    logic [4:0]  o_reg_hart;
    logic [15:0] o_reg_addr;
    logic [31:0] o_reg_wdata;
    logic        i_reg_ack = 1'b0, i_reg_err = 1'b0;
    logic [31:0] i_reg_rdata = '0;
    logic        o_sb_req, o_sb_we;
    logic [31:0] o_sb_addr, o_sb_wdata;
    logic        i_sb_ready = 1'b0, i_sb_err = 1'b0;
    logic [31:0] i_sb_rdata = '0;

    int n_tests = 0, n_fail = 0;
    logic [31:0] rd;

    localparam logic [6:0] DATA0 = 7'h04, DMCTL = 7'h10, DMSTAT = 7'h11, ACS = 7'h16,
                           CMD = 7'h17, SBCS = 7'h38, SBADDR = 7'h39, SBDATA = 7'h3C;

    dm_multihart #(.NHARTS(4), .DATA_COUNT(2), .PROGBUF_SIZE(4), .SB_TIMEOUT(255)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_dmi_wr(i_dmi_wr), .i_dmi_rd(i_dmi_rd), .i_dmi_addr(i_dmi_addr),
        .i_dmi_wdata(i_dmi_wdata), .o_dmi_rdata(o_dmi_rdata),
        .o_haltreq(o_haltreq), .o_resumereq(o_resumereq),
        .i_halted(i_halted), .i_resumeack(i_resumeack),
        .o_reg_req(o_reg_req), .o_reg_write(o_reg_write), .o_reg_hart(o_reg_hart),
        .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
        .i_reg_ack(i_reg_ack), .i_reg_err(i_reg_err), .i_reg_rdata(i_reg_rdata),
        .o_sb_req(o_sb_req), .o_sb_we(o_sb_we), .o_sb_addr(o_sb_addr), .o_sb_wdata(o_sb_wdata),
        .i_sb_ready(i_sb_ready), .i_sb_err(i_sb_err), .i_sb_rdata(i_sb_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
        i_dmi_wr = 1'b1; i_dmi_addr = addr; i_dmi_wdata = data;
        @(negedge i_clk);
        i_dmi_wr = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] addr, output logic [31:0] data);
        i_dmi_rd = 1'b1; i_dmi_addr = addr;
        @(negedge i_clk);
        i_dmi_rd = 1'b0;
        data = o_dmi_rdata;
    endtask

    task automatic sb_serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata);
        int k = 0;
        while (!o_sb_req && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check_eq({tag, " sb_req"}, {31'd0, o_sb_req}, 32'd1);
        if (o_sb_req) begin
            check_eq({tag, " sb_addr"}, o_sb_addr, exp_addr);
            check_eq({tag, " sb_we"}, {31'd0, o_sb_we}, {31'd0, exp_we});
            if (exp_we) check_eq({tag, " sb_wdata"}, o_sb_wdata, exp_wdata);
            i_sb_ready = 1'b1; i_sb_rdata = rdata;
            @(negedge i_clk);
            i_sb_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge i_clk);
        check_eq("reset outputs", {o_haltreq, o_resumereq, 22'd0, o_reg_req, o_sb_req}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        dmi_read(ACS, rd);    check_eq("reset abstractcs", rd, 32'h04000002);
        dmi_read(SBCS, rd);   check_eq("reset sbcs", rd, 32'h20040404);
        dmi_read(DMSTAT, rd); check_eq("reset dmstatus", rd, 32'h00000C82);
        dmi_write(DMCTL, 32'h1);
        dmi_read(DMCTL, rd);  check_eq("dmactive", rd, 32'h1);

        // progbuf / data storage and out-of-range addresses
        dmi_write(7'h21, 32'h0000ABCD); dmi_read(7'h21, rd); check_eq("progbuf1", rd, 32'h0000ABCD);
        dmi_write(7'h24, 32'h12345678); dmi_read(7'h24, rd); check_eq("progbuf4 absent", rd, 32'h0);
        dmi_write(7'h06, 32'h12345678); dmi_read(7'h06, rd); check_eq("data2 absent", rd, 32'h0);

        // abstract write to halted hart 2
        i_halted = 4'b0100;
        dmi_write(DMCTL, 32'h00020001);
        dmi_write(DATA0, 32'hDEADBEEF);
        dmi_write(CMD, 32'h00231005);
        check_eq("t1 reg_req", {31'd0, o_reg_req}, 32'd1);
        check_eq("t1 reg_write", {31'd0, o_reg_write}, 32'd1);
        check_eq("t1 reg_hart", {27'd0, o_reg_hart}, 32'd2);
        check_eq("t1 reg_addr", {16'd0, o_reg_addr}, 32'h1005);
        check_eq("t1 reg_wdata", o_reg_wdata, 32'hDEADBEEF);
        repeat (2) @(negedge i_clk);
        check_eq("t1 reg_req cycle3", {31'd0, o_reg_req}, 32'd1);
        @(negedge i_clk);
        i_reg_ack = 1'b1;
        @(negedge i_clk);
        i_reg_ack = 1'b0;
        check_eq("t1 reg_req after ack", {31'd0, o_reg_req}, 32'd0);
        dmi_read(ACS, rd); check_eq("t1 busy after ack", rd, 32'h04001002);
        dmi_read(ACS, rd); check_eq("t1 idle", rd, 32'h04000002);

        // running hart -> cmderr 4, then ignored, then W1C
        dmi_write(DMCTL, 32'h00010001);
        dmi_write(CMD, 32'h00221000);
        check_eq("t2 no reg_req", {31'd0, o_reg_req}, 32'd0);
        dmi_write(DMCTL, 32'h00020001);
        dmi_write(CMD, 32'h00231005);
        check_eq("t2 ignored no reg_req", {31'd0, o_reg_req}, 32'd0);
        dmi_read(ACS, rd); check_eq("t2 cmderr4", rd, 32'h04000402);
        dmi_write(ACS, 32'h700);
        dmi_read(ACS, rd); check_eq("t2 w1c", rd, 32'h04000002);
        dmi_write(CMD, 32'h00331000);
        dmi_read(ACS, rd); check_eq("t2 aarsize cmderr2", rd, 32'h04000202);
        dmi_write(ACS, 32'h700);

        // stalled read with overlapping command and data writes
        i_reg_rdata = 32'h12345678;
        dmi_write(CMD, 32'h00221007);
        check_eq("t3 reg_req", {31'd0, o_reg_req}, 32'd1);
        check_eq("t3 reg_write", {31'd0, o_reg_write}, 32'd0);
        dmi_write(CMD, 32'h00221008);
        dmi_write(DATA0, 32'hAAAA5555);
        check_eq("t3 reg_addr stable", {16'd0, o_reg_addr}, 32'h1007);
        repeat (7) @(negedge i_clk);
        check_eq("t3 reg_req stalled", {31'd0, o_reg_req}, 32'd1);
        i_reg_ack = 1'b1;
        @(negedge i_clk);
        i_reg_ack = 1'b0;
        check_eq("t3 reg_req dropped", {31'd0, o_reg_req}, 32'd0);
        @(negedge i_clk);
        dmi_read(ACS, rd);   check_eq("t3 cmderr1", rd, 32'h04000102);
        dmi_read(DATA0, rd); check_eq("t3 data0", rd, 32'h12345678);
        dmi_write(ACS, 32'h700);

        // faulted access -> cmderr 3, data0 untouched
        dmi_write(CMD, 32'h00221009);
        i_reg_ack = 1'b1; i_reg_err = 1'b1; i_reg_rdata = 32'hFFFFFFFF;
        @(negedge i_clk);
        i_reg_ack = 1'b0; i_reg_err = 1'b0;
        @(negedge i_clk);
        dmi_read(ACS, rd);   check_eq("t3 cmderr3", rd, 32'h04000302);
        dmi_read(DATA0, rd); check_eq("t3 data0 kept", rd, 32'h12345678);
        dmi_write(ACS, 32'h700);

        // SB reads with readonaddr / readondata / autoincrement
        dmi_write(SBCS, 32'h00158000);
        dmi_read(SBCS, rd); check_eq("t4 sbcs", rd, 32'h20158404);
        dmi_write(SBADDR, 32'h00001000);
        sb_serve("t4 rd0", 32'h1000, 1'b0, 32'h0, 32'h11111111);
        dmi_read(SBDATA, rd); check_eq("t4 sbdata0 #1", rd, 32'h11111111);
        sb_serve("t4 rd1", 32'h1004, 1'b0, 32'h0, 32'h22222222);
        dmi_read(SBDATA, rd); check_eq("t4 sbdata0 #2", rd, 32'h22222222);
        sb_serve("t4 rd2", 32'h1008, 1'b0, 32'h0, 32'h33333333);
        dmi_read(SBADDR, rd); check_eq("t4 sbaddress0", rd, 32'h0000100C);

        // SB write, busy error, access-size error
        dmi_write(SBCS, 32'h00040000);
        dmi_write(SBDATA, 32'hCAFEF00D);
        sb_serve("t4 wr", 32'h100C, 1'b1, 32'hCAFEF00D, 32'h0);
        dmi_write(SBDATA, 32'h1);
        dmi_write(SBDATA, 32'h2);
        sb_serve("t4 busy wr", 32'h100C, 1'b1, 32'h1, 32'h0);
        dmi_read(SBCS, rd); check_eq("t4 sbbusyerror", rd, 32'h20440404);
        dmi_write(SBCS, 32'h00440000);
        dmi_read(SBCS, rd); check_eq("t4 busyerror clr", rd, 32'h20040404);
        dmi_write(SBCS, 32'h0);
        dmi_write(SBDATA, 32'h3);
        check_eq("t4 bad access no req", {31'd0, o_sb_req}, 32'd0);
        dmi_read(SBCS, rd); check_eq("t4 sberror4", rd, 32'h20004404);
        dmi_write(SBCS, 32'h00047000);
        dmi_read(SBCS, rd); check_eq("t4 sberror clr", rd, 32'h20040404);

        // SB timeout
        dmi_write(SBDATA, 32'h5);
        cnt = 0;
        for (int k = 0; k < 400 && o_sb_req; k++) begin
            cnt++;
            @(negedge i_clk);
        end
        check_eq("t5 timeout cycles", cnt, 32'd255);
        dmi_read(SBCS, rd); check_eq("t5 sberror1", rd, 32'h20041404);
        dmi_write(SBDATA, 32'h6);
        check_eq("t5 blocked req", {31'd0, o_sb_req}, 32'd0);
        @(negedge i_clk);
        check_eq("t5 still blocked", {31'd0, o_sb_req}, 32'd0);
        dmi_write(SBCS, 32'h00041000);
        dmi_write(SBDATA, 32'h7);
        sb_serve("t5 after clear", 32'h100C, 1'b1, 32'h7, 32'h0);

        // halt / resume on hart 0
        dmi_write(DMCTL, 32'hC0000001);
        check_eq("t6 haltreq", {28'd0, o_haltreq}, 32'h1);
        check_eq("t6 resume ignored", {28'd0, o_resumereq}, 32'h0);
        dmi_write(DMCTL, 32'h40000001);
        check_eq("t6 haltreq clr", {28'd0, o_haltreq}, 32'h0);
        check_eq("t6 resumereq", {28'd0, o_resumereq}, 32'h1);
        i_resumeack = 4'b0001;
        @(negedge i_clk);
        i_resumeack = 4'b0000;
        check_eq("t6 resumereq clr", {28'd0, o_resumereq}, 32'h0);
        dmi_read(DMSTAT, rd); check_eq("t6 dmstatus ack", rd, 32'h00030C82);
        dmi_write(DMCTL, 32'h80050001);
        check_eq("t6 nonexistent haltreq", {28'd0, o_haltreq}, 32'h0);
        dmi_read(DMSTAT, rd); check_eq("t6 dmstatus nonexist", rd, 32'h0000C082);

        // dmactive=0 during an SB access
        dmi_write(DMCTL, 32'h80020001);
        check_eq("t7 haltreq hart2", {28'd0, o_haltreq}, 32'h4);
        dmi_write(SBDATA, 32'h77);
        check_eq("t7 sb_req up", {31'd0, o_sb_req}, 32'd1);
        dmi_write(DMCTL, 32'h0);
        check_eq("t7 sb_req cleared", {31'd0, o_sb_req}, 32'd0);
        check_eq("t7 haltreq cleared", {28'd0, o_haltreq}, 32'h0);
        dmi_read(ACS, rd);    check_eq("t7 abstractcs", rd, 32'h04000002);
        dmi_read(SBCS, rd);   check_eq("t7 sbcs", rd, 32'h20040404);
        dmi_read(DMCTL, rd);  check_eq("t7 dmcontrol", rd, 32'h0);
        dmi_read(SBADDR, rd); check_eq("t7 sbaddress0", rd, 32'h0);
        dmi_read(DATA0, rd);  check_eq("t7 data0", rd, 32'h0);
        dmi_read(7'h21, rd);  check_eq("t7 progbuf1", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_multihart.md
Name: dm_multihart

Overview:
Parametrised RISC-V Debug Module (v0.13.2 register map) for multi-hart systems. It sits between the DTM-side DMI bus and up to 32 harts, plus one system-bus master port. Abstract register access uses a req/ack handshake instead of fixed latency. System-bus access adds autoincrement, read-on-data, timeout and error reporting. dmi_rdata is registered.

Parameters:
NHARTS, 4, number of harts (1..32); hartsel widths above 5 bits read as 0
DATA_COUNT, 2, implemented data0..dataN-1 registers at 0x04+ (1..12)
PROGBUF_SIZE, 4, implemented progbuf words at 0x20+ (0..16); storage only, never executed
SB_TIMEOUT, 255, cycles without sb_ready before a bus access is aborted

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
dmi_wr  in  1  DMI write strobe, one cycle
dmi_rd  in  1  DMI read strobe, one cycle
dmi_addr  in  7  DMI register address
dmi_wdata  in  32  DMI write data
dmi_rdata  out  32  read data, valid the cycle after dmi_rd, held until next dmi_rd
haltreq  out  NHARTS  per-hart halt request, level
resumereq  out  NHARTS  per-hart resume request, held until matching resumeack
halted  in  NHARTS  per-hart halted status
resumeack  in  NHARTS  per-hart resume acknowledge pulse
reg_req  out  1  abstract register access request
reg_write  out  1  1 = write, 0 = read; stable while reg_req
reg_hart  out  5  target hart
reg_addr  out  16  regno
reg_wdata  out  32  write data (data0)
reg_ack  in  1  access complete
reg_err  in  1  access faulted, sampled with reg_ack
reg_rdata  in  32  read data, sampled with reg_ack
sb_req  out  1  bus request
sb_we  out  1  bus write enable
sb_addr  out  32  bus address
sb_wdata  out  32  bus write data
sb_ready  in  1  bus completion
sb_err  in  1  bus error, sampled with sb_ready
sb_rdata  in  32  bus read data

Behaviour:
- Reset (reset low): every output is 0. All registers are 0 except abstractcs.datacount = DATA_COUNT, progbufsize = PROGBUF_SIZE, and sbcs.sbversion = 1, sbasize = 32, sbaccess32 = 1, sbaccess = 2.
- dmcontrol (0x10) bit fields:
  - bit0 dmactive: writing 0 clears all DM state and outputs as reset does, and aborts any in-flight reg_req/sb_req the same cycle.
  - hartsel[25:16]: index of the selected hart.
  - haltreq[31]: drives haltreq[hartsel] while set; other bits 0.
  - resumereq[30]=1 sets a sticky resumereq[hartsel] and clears that hart's resumeack flag; both are ignored if haltreq=1.
  - A resumeack[h] pulse clears resumereq[h] and sets that hart's resumeack flag.
- dmstatus (0x11), read-only, reports the selected hart only: allhalted = anyhalted = halted[sel]; allrunning = anyrunning = ~halted[sel]; allresumeack = anyresumeack = flag[sel]; authenticated = 1; version = 2. If hartsel >= NHARTS: nonexistent = 1 and halted/running = 0.
- abstractcs (0x16): cmderr[10:8] is W1C; busy is [12]. A write to command (0x17) is decoded in this order:
  - busy: cmderr = 1 (busy).
  - cmderr != 0: ignored.
  - cmdtype[31:24] != 0, aarsize[22:20] != 2, or postexec[18] = 1: cmderr = 2.
  - Hart nonexistent or not halted: cmderr = 4.
  - transfer[17] = 0: no-op, busy clears the next cycle.
  - Otherwise: FSM IDLE -> REQ.
- Abstract FSM:
  - IDLE -> REQ: reg_req = 1 one cycle after the command write; reg_write = write[16]; reg_addr = regno; reg_wdata = data0.
  - REQ: hold until reg_ack. On reg_err, cmderr = 3; otherwise a read loads data0 from reg_rdata. Then -> DONE.
  - DONE -> IDLE: busy clears.
  - A DMI write to any data register while busy sets cmderr = 1 and is dropped.
- Data and progbuf: addresses beyond DATA_COUNT or PROGBUF_SIZE read 0 and ignore writes. Other unmapped addresses behave the same.
- sbcs (0x38) bit fields:
  - sbbusyerror[22]: W1C.
  - sbbusy[21]: read-only.
  - sbreadonaddr[20], sbautoincrement[16], sbreadondata[15]: R/W.
  - sbaccess[19:17]: R/W.
  - sberror[14:12]: W1C.
- SB start conditions, each accepted only when sberror = 0, sbbusyerror = 0 and sbbusy = 0:
  - Write to sbaddress0 (0x39) with readonaddr: start a read.
  - Write to sbdata0 (0x3C): start a write.
  - dmi_rd of sbdata0 with readondata: start a read after returning the current data.
- SB gating:
  - Start attempted while sbbusy: sbbusyerror = 1; the address/data write itself still updates the register.
  - sbaccess != 2: sberror = 4, no transaction.
- SB transaction:
  - sb_req rises the cycle after the start and is held with stable sb_addr/sb_we/sb_wdata until sb_ready.
  - On completion, a read loads sbdata0. If autoincrement, sbaddress0 += 4 with 32-bit wrap.
  - sb_err with sb_ready: sberror = 7, no increment.
  - SB_TIMEOUT cycles without sb_ready: drop sb_req, sberror = 1.
- Abstract and SB engines run concurrently and independently.

Test Plan:
- Hart 2 halted, data0 = 0xDEADBEEF, command = 0x00231005; reg_ack after 3 cycles -> reg_req 1 for 4 cycles, reg_write = 1, reg_hart = 2, reg_addr = 0x1005, reg_wdata = 0xDEADBEEF; busy clears 1 cycle after reg_ack; cmderr = 0.
- Hart 1 running, read command to hart 1 -> cmderr = 4, no reg_req. Second command -> ignored. W1C 0x700 to abstractcs -> cmderr = 0.
- Read command, reg_ack stalled 10 cycles, second command write during the stall -> cmderr = 1; first access completes and data0 = reg_rdata.
- sbcs = readonaddr | autoincrement | readondata | sbaccess = 2, sbaddress0 = 0x1000, then two sbdata0 reads -> reads at 0x1000, 0x1004, 0x1008; sbaddress0 = 0x100C.
- sb_ready never asserted, SB_TIMEOUT = 255 -> sb_req drops after 255 cycles; sberror = 1; next sbdata0 write issues no sb_req until sberror is cleared.
- haltreq + resumereq for hart 0, then clear haltreq and set resumereq, then resumeack[0] pulse -> resumereq[0] clears and allresumeack = 1. Writing dmactive = 0 mid-SB-access -> sb_req = 0 the next cycle and all registers at reset values.
